// File: rtl/genesis_pad_responder_if.sv
// rtl/genesis_pad_responder_if.sv - controller-port signal bundle between core and pad emulator
// The responder takes the slave side; the core's pad reader takes the master side.
interface genesis_pad_responder_if;
   logic [11:0] joy;
   logic        mode6;
   logic        th;
   logic [5:0]  pad_out;
   logic [2:0]  phase;

   modport slave (
      input  joy,
      input  mode6,
      input  th,
      output pad_out,
      output phase
   );

   modport master (
      output joy,
      output mode6,
      output th,
      input  pad_out,
      input  phase
   );
endinterface

// File: rtl/genesis_pad_responder.sv
// rtl/genesis_pad_responder.sv - Genesis/Mega Drive pad emulator driven by the core's TH select line
// Tracks TH edges into a 3-bit phase {pair, low} and presents the matching active-low button group.
module genesis_pad_responder #(
   parameter int unsigned TIMEOUT_CYCLES = 75000
) (
   input  logic                    clk,
   input  logic                    reset_n,
   genesis_pad_responder_if.slave  pad
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

   logic          th_s1_q, th_s2_q, th_d_q;
   logic [1:0]    pair_q, pair_d;
   logic          low_q, low_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [5:0]    pad_q, pad_d;
   logic [2:0]    phase_d;
   logic          trans;
   logic          timeout;

   assign trans   = (th_s2_q != th_d_q);
   assign timeout = (cnt_q == CNT_MAX);

   always_comb begin
      pair_d = pair_q;
      low_d  = low_q;
      cnt_d  = cnt_q;
      // A TH edge always takes priority over a timeout landing on the same cycle.
      if (trans) begin
         low_d = ~th_s2_q;
         cnt_d = '0;
         if (th_s2_q) begin
            pair_d = pair_q + 2'd1;
         end
      end else if (timeout) begin
         pair_d = 2'd0;
         low_d  = ~th_s2_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
      if (!pad.mode6) begin
         pair_d = 2'd0;
      end
   end

   assign phase_d = {pair_d, low_d};

   always_comb begin
      pad_d = 6'h3F;
      case (phase_d)
         3'd0, 3'd2, 3'd4: pad_d = {~pad.joy[6], ~pad.joy[5], ~pad.joy[0], ~pad.joy[1], ~pad.joy[2], ~pad.joy[3]};
         3'd1, 3'd3:       pad_d = {~pad.joy[7], ~pad.joy[4], 2'b00, ~pad.joy[2], ~pad.joy[3]};
         3'd5:             pad_d = {~pad.joy[7], ~pad.joy[4], 4'b0000};
         3'd6:             pad_d = {~pad.joy[6], ~pad.joy[5], ~pad.joy[8], ~pad.joy[9], ~pad.joy[10], ~pad.joy[11]};
         default:          pad_d = {~pad.joy[7], ~pad.joy[4], 4'b1111};
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         th_s1_q <= 1'b1;
         th_s2_q <= 1'b1;
         th_d_q  <= 1'b1;
         pair_q  <= 2'd0;
         low_q   <= 1'b0;
         cnt_q   <= '0;
         pad_q   <= 6'h3F;
      end else begin
         th_s1_q <= pad.th;
         th_s2_q <= th_s1_q;
         th_d_q  <= th_s2_q;
         pair_q  <= pair_d;
         low_q   <= low_d;
         cnt_q   <= cnt_d;
         pad_q   <= pad_d;
      end
   end

   assign pad.pad_out = pad_q;
   assign pad.phase   = {pair_q, low_q};

endmodule

// File: tb/tb_genesis_pad_responder.sv
// tb/tb_genesis_pad_responder.sv - directed scoreboard bench for genesis_pad_responder
// Expected phase/pad pairs are queued as stimulus is applied and popped at each sample point.
module tb_genesis_pad_responder;

   localparam int T = 64;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   genesis_pad_responder_if pif ();

   genesis_pad_responder #(
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .pad     (pif)
   );

   typedef struct {
      string      tag;
      logic [2:0] ph;
      logic [5:0] pad;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   function automatic logic [5:0] model(input logic [2:0] ph, input logic [11:0] j);
      logic r, l, d, u, a, b, c, st, md, x, y, z;
      {z, y, x, md, st, c, b, a, u, d, l, r} = j;
      case (ph)
         3'd1, 3'd3: return {!st, !a, 1'b0, 1'b0, !d, !u};
         3'd5:       return {!st, !a, 4'h0};
         3'd6:       return {!c, !b, !md, !x, !y, !z};
         3'd7:       return {!st, !a, 4'hF};
         default:    return {!c, !b, !r, !l, !d, !u};
      endcase
   endfunction

   task automatic push_raw(input string tag, input logic [2:0] ph, input logic [5:0] p);
      exp_t e;
      e.tag = tag;
      e.ph  = ph;
      e.pad = p;
      sb.push_back(e);
   endtask

   task automatic push(input string tag, input logic [2:0] ph);
      push_raw(tag, ph, model(ph, pif.joy));
   endtask

   task automatic pop_check();
      exp_t e;
      e = sb.pop_front();
      tests += 2;
      assert (pif.phase === e.ph) else begin
         fails++;
         $error("FAIL %s phase observed=%0d expected=%0d", e.tag, pif.phase, e.ph);
      end
      assert (pif.pad_out === e.pad) else begin
         fails++;
         $error("FAIL %s pad_out observed=%b expected=%b", e.tag, pif.pad_out, e.pad);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic toggle_step(input string tag, input logic [2:0] ph);
      pif.th = ~pif.th;
      clk_n(20);
      push(tag, ph);
      pop_check();
   endtask

   initial begin
      reset_n   = 1'b0;
      pif.th    = 1'b1;
      pif.mode6 = 1'b1;
      pif.joy   = 12'h001;
      clk_n(3);
      push_raw("in_reset", 3'd0, 6'h3F);
      pop_check();

      reset_n = 1'b1;
      clk_n(3);
      push("idle_r", 3'd0);
      pop_check();

      pif.joy = 12'h0F0;
      clk_n(1);
      push("joy_step", 3'd0);
      pop_check();

      // Latency: TH fall is visible on the third rising edge, not the second.
      pif.th = 1'b0;
      clk_n(2);
      push("lat_old", 3'd0);
      pop_check();
      clk_n(1);
      push("lat_new", 3'd1);
      pop_check();
      clk_n(17);
      for (int p = 2; p < 8; p++) toggle_step("seq6", 3'(p));
      toggle_step("wrap", 3'd0);

      pif.joy = 12'hF00;
      clk_n(1);
      push("joy_mxyz", 3'd0);
      pop_check();
      for (int p = 1; p < 6; p++) toggle_step("to6", 3'(p));
      pif.th = ~pif.th;
      clk_n(T + 2);
      push("pre_timeout", 3'd6);
      pop_check();
      clk_n(1);
      push("timeout", 3'd0);
      pop_check();

      pif.joy = 12'h0F0;
      for (int p = 1; p < 6; p++) toggle_step("coin_walk", 3'(p));
      pif.th = ~pif.th;
      clk_n(T);
      push("coin_pre", 3'd6);
      pop_check();
      pif.th = ~pif.th;
      clk_n(2);
      push("coin_hold", 3'd6);
      pop_check();
      clk_n(1);
      push("coin_adv", 3'd7);
      pop_check();
      tests++;
      assert (dut.cnt_q === '0) else begin
         fails++;
         $error("FAIL coin_cnt counter observed=%0d expected=0", dut.cnt_q);
      end

      pif.mode6 = 1'b0;
      pif.joy   = 12'h00C;
      clk_n(1);
      push("m3_enter", 3'd1);
      pop_check();
      for (int i = 0; i < 8; i++) begin
         pif.th = ~pif.th;
         clk_n(20);
         push("m3_toggle", pif.th ? 3'd0 : 3'd1);
         pop_check();
      end

      pif.mode6 = 1'b1;
      clk_n(1);
      push("m6_back", 3'd1);
      pop_check();
      for (int p = 2; p < 6; p++) toggle_step("to5", 3'(p));

      reset_n = 1'b0;
      clk_n(1);
      push_raw("rst_mid", 3'd0, 6'h3F);
      pop_check();
      reset_n = 1'b1;
      clk_n(1);
      push("post_rst", 3'd0);
      pop_check();
      clk_n(2);
      push("fall_after_rst", 3'd1);
      pop_check();

      tests++;
      assert (sb.size() == 0) else begin
         fails++;
         $error("FAIL sb_drain leftover observed=%0d expected=0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
